xbar_cfg_ctrl: RTL

Configuration controller for the LUT-tile input crossbar (19 inputs, 24 outputs, 5-bit select per output, 120 config bits). It takes per-output select writes over a valid/ready port and stages them in a shadow register. It then commits the whole set atomically to the active `io_mux_configs` bus, but only when the datapath deasserts `io_hold`. The crossbar therefore never sees a partially updated routing. It sits between the tile configuration interface and the crossbar's `io_mux_configs` input.

---
 rtl/xbar_cfg_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/xbar_cfg_ctrl.sv
// Shadow/active configuration controller for the LUT-tile input crossbar.
// Select writes stage into shadow; a commit copies shadow to active atomically once io_hold drops.
module xbar_cfg_ctrl #(
    parameter int NUM_IN  = 19,
    parameter int NUM_OUT = 24,
    parameter int SEL_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_wr_valid,
    output logic                     io_wr_ready,
    input  logic [SEL_W-1:0]         io_wr_addr,
    input  logic [SEL_W-1:0]         io_wr_sel,
    input  logic                     io_commit_valid,
    output logic                     io_commit_ready,
    input  logic                     io_hold,
    output logic                     io_commit_done,
    output logic                     io_err,
    input  logic                     io_err_clear,
    output logic [7:0]               io_cfg_epoch,
    output logic [NUM_OUT*SEL_W-1:0] io_mux_configs
);

    localparam int CFG_W = NUM_OUT * SEL_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   active_q, active_d;
    logic [7:0]         epoch_q, epoch_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               wr_fire;
    logic               commit_fire;
    logic               wr_legal;

    // Readies decode from state alone so upstream never sees a combinational path.
    assign io_wr_ready     = (state_q == ST_IDLE);
    assign io_commit_ready = (state_q == ST_IDLE);

    assign wr_fire     = io_wr_valid & io_wr_ready;
    assign commit_fire = io_commit_valid & io_commit_ready;
    assign wr_legal    = (int'(io_wr_addr) < NUM_OUT) && (int'(io_wr_sel) < NUM_IN);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        epoch_d  = epoch_q;
        err_d    = err_q;
        done_d   = 1'b0;

        if (io_err_clear) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A same-cycle write lands in shadow_d, which is what WAIT later copies.
                if (wr_fire) begin
                    if (wr_legal) begin
                        for (int k = 0; k < NUM_OUT; k++) begin
                            if (io_wr_addr == SEL_W'(k)) begin
                                shadow_d[k*SEL_W +: SEL_W] = io_wr_sel;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (commit_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!io_hold) begin
                    active_d = shadow_q;
                    epoch_d  = epoch_q + 8'd1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            active_q <= '0;
            epoch_q  <= 8'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            epoch_q  <= epoch_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign io_mux_configs = active_q;
    assign io_cfg_epoch   = epoch_q;
    assign io_err         = err_q;
    assign io_commit_done = done_q;

endmodule
